// File: rtl/dwc_lockstep_checker.sv
// Dual-core lockstep result checker.
// Buffers core A / core B result words in per-side FIFOs, pops them pairwise,
// compares each pair one cycle later, counts compares and mismatches, and
// latches a fault on a mismatch threshold or on sustained stream skew.

// Per-side result FIFO with a synchronous flush. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module dwc_lockstep_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]               wr_q, rd_q;
   logic [DEPTH-1:0][W-1:0]   mem_q;

   // Storage needs no reset; only the pointers define occupancy.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_q[AW-1:0]] <= wdata;
   end

   // Pointer update; flush wins over any same-cycle push/pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + PTR_ONE;
         if (pop)  rd_q <= rd_q + PTR_ONE;
      end
   end

   assign rdata = mem_q[rd_q[AW-1:0]];
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

module dwc_lockstep_checker #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 4,
   parameter int SKEW_MAX = 16
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              cfg_enable,
   input  logic              cfg_clear,
   input  logic [7:0]        cfg_threshold,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic [31:0]       cmp_cnt,
   output logic [15:0]       mis_cnt,
   output logic              fault,
   output logic              skew_err,
   output logic [DATA_W-1:0] fault_a,
   output logic [DATA_W-1:0] fault_b
);
   localparam int SW = $clog2(SKEW_MAX + 1);
   localparam logic [SW-1:0] SKEW_LIM = SW'(SKEW_MAX);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

   state_t                   state_q;
   logic                     run;
   logic [1:0]               vld_in, rdy, push, full, empty;
   logic [1:0][DATA_W-1:0]   din, dout;
   logic                     pop, flush, leave_run;

   logic                     cmp_vld_q;
   logic [DATA_W-1:0]        cmp_a_q, cmp_b_q;
   logic [31:0]              cmp_cnt_q;
   logic [15:0]              mis_cnt_q;
   logic [SW-1:0]            skew_q, skew_d;
   logic                     skew_err_q;
   logic [DATA_W-1:0]        fault_a_q, fault_b_q;

   logic                     mis_now, thr_hit, skew_cond, skew_hit, fault_hit;
   logic [16:0]              mis_inc;

   assign run    = (state_q == S_RUN);
   assign vld_in = {b_valid, a_valid};
   assign din    = {b_data, a_data};

   // Both sides pop together so the streams stay paired by position.
   assign pop = run && !empty[0] && !empty[1];

   // Compare stage: threshold is sampled live against the post-increment count.
   assign mis_now = cmp_vld_q && (cmp_a_q != cmp_b_q);
   assign mis_inc = {1'b0, mis_cnt_q} + 17'd1;
   assign thr_hit = mis_now && run && (cfg_threshold != 8'd0) &&
                    (mis_inc >= {9'd0, cfg_threshold});

   // Skew: one side has backed up completely while the other has nothing.
   assign skew_cond = run && ((full[0] && empty[1]) || (full[1] && empty[0]));
   assign skew_d    = skew_cond ? skew_q + SW'(1) : '0;
   assign skew_hit  = skew_cond && (skew_d == SKEW_LIM);
   assign fault_hit = thr_hit || skew_hit;

   // Disabling drops whatever is buffered; faulting keeps it for debug.
   assign leave_run = run && !cfg_enable && !fault_hit;
   assign flush     = cfg_clear || leave_run;

   for (genvar s = 0; s < 2; s++) begin : g_side
      // Ready depends only on registered state, never on valid.
      assign rdy[s]  = run && !full[s];
      assign push[s] = vld_in[s] && rdy[s];

      dwc_lockstep_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
         .clk   (ACLK),
         .rst   (ARESET),
         .flush (flush),
         .push  (push[s]),
         .pop   (pop),
         .wdata (din[s]),
         .rdata (dout[s]),
         .full  (full[s]),
         .empty (empty[s])
      );
   end

   // Compare pipeline, counters and skew counter; clear discards in-flight work.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         cmp_vld_q <= 1'b0;
         cmp_a_q   <= '0;
         cmp_b_q   <= '0;
         cmp_cnt_q <= '0;
         mis_cnt_q <= '0;
         skew_q    <= '0;
      end else if (cfg_clear) begin
         cmp_vld_q <= 1'b0;
         cmp_a_q   <= '0;
         cmp_b_q   <= '0;
         cmp_cnt_q <= '0;
         mis_cnt_q <= '0;
         skew_q    <= '0;
      end else begin
         cmp_vld_q <= pop;
         if (pop) begin
            cmp_a_q <= dout[0];
            cmp_b_q <= dout[1];
         end
         if (cmp_vld_q) cmp_cnt_q <= cmp_cnt_q + 32'd1;
         if (mis_now && (mis_cnt_q != 16'hFFFF)) mis_cnt_q <= mis_cnt_q + 16'd1;
         skew_q <= skew_d;
      end
   end

   // Control FSM with latched fault cause and captured mismatching pair.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q    <= S_IDLE;
         skew_err_q <= 1'b0;
         fault_a_q  <= '0;
         fault_b_q  <= '0;
      end else if (cfg_clear) begin
         state_q    <= S_IDLE;
         skew_err_q <= 1'b0;
         fault_a_q  <= '0;
         fault_b_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (cfg_enable) state_q <= S_RUN;
            S_RUN: begin
               if (fault_hit) begin
                  state_q <= S_FAULT;
                  if (thr_hit) begin
                     fault_a_q <= cmp_a_q;
                     fault_b_q <= cmp_b_q;
                  end
                  if (skew_hit) skew_err_q <= 1'b1;
               end else if (!cfg_enable) begin
                  state_q <= S_IDLE;
               end
            end
            S_FAULT: state_q <= S_FAULT;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign a_ready  = rdy[0];
   assign b_ready  = rdy[1];
   assign cmp_cnt  = cmp_cnt_q;
   assign mis_cnt  = mis_cnt_q;
   assign fault    = (state_q == S_FAULT);
   assign skew_err = skew_err_q;
   assign fault_a  = fault_a_q;
   assign fault_b  = fault_b_q;
endmodule

// File: tb/tb_dwc_lockstep_checker.sv
// Bench for dwc_lockstep_checker: directed scenarios plus a random phase, all
// compared every cycle against a queue-based reference of the checker.
module tb_dwc_lockstep_checker;
   localparam int DW       = 32;
   localparam int DEPTH    = 4;
   localparam int SKEW_MAX = 16;

   logic          ACLK = 1'b0;
   logic          ARESET = 1'b1;
   logic          cfg_enable = 1'b0;
   logic          cfg_clear = 1'b0;
   logic [7:0]    cfg_threshold = 8'd0;
   logic          a_valid = 1'b0, b_valid = 1'b0;
   logic [DW-1:0] a_data = '0, b_data = '0;
   logic          a_ready, b_ready, fault, skew_err;
   logic [31:0]   cmp_cnt;
   logic [15:0]   mis_cnt;
   logic [DW-1:0] fault_a, fault_b;

   dwc_lockstep_checker #(.DATA_W(DW), .DEPTH(DEPTH), .SKEW_MAX(SKEW_MAX)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .cfg_enable(cfg_enable), .cfg_clear(cfg_clear),
      .cfg_threshold(cfg_threshold),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .cmp_cnt(cmp_cnt), .mis_cnt(mis_cnt), .fault(fault), .skew_err(skew_err),
      .fault_a(fault_a), .fault_b(fault_b)
   );

   always #5 ACLK = ~ACLK;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sources (what each core still has to deliver) and reference state.
   logic [DW-1:0] a_src[$], b_src[$];
   bit            a_en = 1'b1, b_en = 1'b1;
   logic [DW-1:0] qa[$], qb[$];
   bit            m_run, m_fault, m_pend, m_skerr;
   logic [DW-1:0] m_pa, m_pb, m_fa, m_fb;
   int            m_cmp, m_mis, m_skew;

   task automatic m_clear();
      m_run = 0; m_fault = 0; m_pend = 0; m_skerr = 0;
      m_pa = '0; m_pb = '0; m_fa = '0; m_fb = '0;
      m_cmp = 0; m_mis = 0; m_skew = 0;
      qa.delete(); qb.delete();
   endtask

   // One clock edge of the reference, using inputs as they stood before it.
   task automatic m_update();
      int na, nb;
      bit acc_a, acc_b, pop, thr_hit, sk_hit;
      logic [DW-1:0] ca, cb;
      if (ARESET || cfg_clear) begin
         m_clear();
         return;
      end
      na = qa.size(); nb = qb.size();
      acc_a = a_valid && m_run && (na < DEPTH);
      acc_b = b_valid && m_run && (nb < DEPTH);
      pop   = m_run && (na > 0) && (nb > 0);
      thr_hit = 0; sk_hit = 0;
      ca = m_pa; cb = m_pb;
      if (m_pend) begin
         m_cmp++;
         if (ca != cb) begin
            if (m_run && cfg_threshold != 0 && m_mis + 1 >= int'(cfg_threshold)) thr_hit = 1;
            if (m_mis < 65535) m_mis++;
         end
      end
      if (m_run && ((na == DEPTH && nb == 0) || (nb == DEPTH && na == 0))) begin
         m_skew++;
         if (m_skew == SKEW_MAX) sk_hit = 1;
      end else m_skew = 0;
      m_pend = pop;
      if (pop) begin
         m_pa = qa.pop_front();
         m_pb = qb.pop_front();
      end
      if (acc_a) begin qa.push_back(a_data); void'(a_src.pop_front()); end
      if (acc_b) begin qb.push_back(b_data); void'(b_src.pop_front()); end
      if (thr_hit || sk_hit) begin
         m_run = 0; m_fault = 1;
         if (thr_hit) begin m_fa = ca; m_fb = cb; end
         if (sk_hit) m_skerr = 1;
      end else if (m_run && !cfg_enable) begin
         m_run = 0;
         qa.delete(); qb.delete();
      end else if (!m_run && !m_fault && cfg_enable) begin
         m_run = 1;
      end
   endtask

   task automatic drive();
      a_valid = a_en && (a_src.size() > 0);
      b_valid = b_en && (b_src.size() > 0);
      a_data  = a_valid ? a_src[0] : $urandom;
      b_data  = b_valid ? b_src[0] : $urandom;
   endtask

   task automatic check_all();
      chk("a_ready",  a_ready,  m_run && qa.size() < DEPTH);
      chk("b_ready",  b_ready,  m_run && qb.size() < DEPTH);
      chk("cmp_cnt",  cmp_cnt,  32'(m_cmp));
      chk("mis_cnt",  mis_cnt,  16'(m_mis));
      chk("fault",    fault,    m_fault);
      chk("skew_err", skew_err, m_skerr);
      chk("fault_a",  fault_a,  m_fa);
      chk("fault_b",  fault_b,  m_fb);
   endtask

   task automatic step();
      @(posedge ACLK);
      m_update();
      @(negedge ACLK);
      check_all();
      drive();
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_clear();
      cfg_clear = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0;
      step();
      cfg_clear = 1'b0;
   endtask

   task automatic load_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
      a_src.push_back(a);
      b_src.push_back(b);
   endtask

   initial begin
      int full_at, sk_at;
      logic [DW-1:0] w;
      m_clear();
      #1;
      chk("rst cmp_cnt", cmp_cnt, 0);
      chk("rst mis_cnt", mis_cnt, 0);
      chk("rst fault", fault, 0);
      chk("rst a_ready", a_ready, 0);
      step();
      ARESET = 1'b0;

      // T1: four identical pairs.
      cfg_enable = 1'b1;
      for (int i = 1; i <= 4; i++) load_pair(i, i);
      drive();
      run_n(10);
      chk("T1 cmp_cnt", cmp_cnt, 4);
      chk("T1 mis_cnt", mis_cnt, 0);
      chk("T1 fault", fault, 0);

      // T2: threshold 2, second mismatch faults.
      pulse_clear();
      cfg_threshold = 8'd2;
      load_pair(5, 5); load_pair(6, 7); load_pair(8, 8); load_pair(9, 'hA);
      drive();
      run_n(12);
      chk("T2 mis_cnt", mis_cnt, 2);
      chk("T2 cmp_cnt", cmp_cnt, 4);
      chk("T2 fault", fault, 1);
      chk("T2 fault_a", fault_a, 9);
      chk("T2 fault_b", fault_b, 'hA);
      chk("T2 a_ready", a_ready, 0);
      chk("T2 b_ready", b_ready, 0);

      // T5a: clear out of FAULT with enable held.
      pulse_clear();
      chk("T5 fault", fault, 0);
      chk("T5 cmp_cnt", cmp_cnt, 0);
      chk("T5 mis_cnt", mis_cnt, 0);
      chk("T5 idle ready", a_ready, 0);
      step();
      chk("T5 run ready", a_ready, 1);

      // T3: threshold 0 never faults.
      cfg_threshold = 8'd0;
      for (int i = 0; i < 20; i++) begin
         w = 100 + i;
         load_pair(w, ~w);
      end
      drive();
      run_n(40);
      chk("T3 mis_cnt", mis_cnt, 20);
      chk("T3 cmp_cnt", cmp_cnt, 20);
      chk("T3 fault", fault, 0);

      // T4: only A drives; skew fault SKEW_MAX cycles after A fills.
      pulse_clear();
      a_src.delete(); b_src.delete();
      b_en = 1'b0;
      for (int i = 0; i < 6; i++) a_src.push_back(32'h40 + i);
      drive();
      full_at = -1; sk_at = -1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (full_at < 0 && !a_ready) full_at = i;
         if (sk_at < 0 && skew_err) sk_at = i;
      end
      chk("T4 skew latency", sk_at - full_at, SKEW_MAX);
      chk("T4 skew_err", skew_err, 1);
      chk("T4 fault", fault, 1);
      chk("T4 fault_a", fault_a, 0);

      // T6: B starts 3 cycles after A; order must be preserved.
      pulse_clear();
      a_src.delete(); b_src.delete();
      b_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         w = $urandom;
         load_pair(w, w);
      end
      drive();
      run_n(4);
      b_en = 1'b1;
      drive();
      run_n(30);
      chk("T6 cmp_cnt", cmp_cnt, 12);
      chk("T6 mis_cnt", mis_cnt, 0);

      // T5b: asynchronous reset in the middle of a burst.
      for (int i = 0; i < 8; i++) load_pair(i, i ^ (i & 1));
      drive();
      run_n(5);
      ARESET = 1'b1;
      #1;
      chk("T5 async cmp_cnt", cmp_cnt, 0);
      chk("T5 async mis_cnt", mis_cnt, 0);
      chk("T5 async a_ready", a_ready, 0);
      chk("T5 async fault", fault, 0);
      step();
      ARESET = 1'b0;

      // Random phase: live threshold changes, enable drops, clears, stalls.
      a_src.delete(); b_src.delete();
      for (int i = 0; i < 400; i++) begin
         cfg_enable = ($urandom_range(0, 15) != 0);
         cfg_clear  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 19) == 0) cfg_threshold = 8'($urandom_range(0, 8));
         a_en = ($urandom_range(0, 3) != 0);
         b_en = ($urandom_range(0, 3) != 0);
         while (a_src.size() < 3) begin
            w = $urandom_range(0, 3);
            a_src.push_back(w);
            b_src.push_back(($urandom_range(0, 5) == 0) ? DW'($urandom_range(0, 3)) : w);
         end
         drive();
         step();
      end
      cfg_clear = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
